inst_fetch: RTL

Instruction fetch stage for the ENGR 468 processor. Sequences a program counter through the instruction ROM and absorbs the ROM's one-cycle synchronous read latency. Presents one 16-bit instruction per cycle, with a valid flag and its address, to the instruction splitter directly downstream. Handles downstream stall, taken branches with a one-cycle bubble, and a HALT opcode that freezes fetching until reset.

---
 rtl/isa_pkg.sv | 29 ++
 rtl/inst_fetch_pc_counter.sv | 36 +++
 rtl/inst_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ENGR 468 instruction-set constants shared by the fetch stage and the splitter:
// field positions/widths, the HALT opcode and the fetch FSM encoding.
package isa_pkg;

    localparam int INST_W   = 16;

    localparam int COND_LSB = 14;
    localparam int COND_W   = 2;
    localparam int OPCD_LSB = 10;
    localparam int OPCD_W   = 4;
    localparam int DEST_LSB = 7;
    localparam int DEST_W   = 3;
    localparam int SRC_LSB  = 4;
    localparam int SRC_W    = 3;
    localparam int SRC2_LSB = 0;
    localparam int SRC2_W   = 4;

    localparam logic [OPCD_W-1:0] HALT_OPCODE = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [OPCD_W-1:0] get_opcd(input logic [INST_W-1:0] inst);
        return inst[OPCD_LSB +: OPCD_W];
    endfunction

endpackage

// File: rtl/inst_fetch_pc_counter.sv
// Fetch program counter: load wins over increment, otherwise hold.
// Arithmetic is ADDR_W bits wide, so the count wraps to 0 after the top address.
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              inc,
    input  logic [ADDR_W-1:0] ld_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ld) begin
            pc_d = ld_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the PC through a 1-cycle-latency ROM and hands
// one instruction per cycle to the splitter, with stall, branch bubble and HALT.
module inst_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [OPCD_W-1:0] HALT_OPCD = HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic advance;
    logic take_branch;
    logic halt_hit;

    assign advance     = (state_q == ST_RUN) & ~stall;
    assign take_branch = branch_en & ~stall;
    assign rom_addr    = take_branch ? branch_target : fetch_pc;
    assign rom_en      = advance;

    // A branch in the same cycle discards the in-flight word, so it cannot halt us.
    assign halt_hit = pend_valid_q & ~branch_en & (get_opcd(rom_data) == HALT_OPCD);

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc_counter (
        .clk    (clk),
        .rst    (rst),
        .ld     (advance & branch_en),
        .inc    (advance & ~branch_en),
        .ld_val (branch_target + ADDR_W'(1)),
        .pc     (fetch_pc)
    );

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        pc_d         = pc_q;

        if (advance) begin
            inst_d       = rom_data;
            pc_d         = pend_pc_q;
            inst_valid_d = pend_valid_q & ~branch_en;
            pend_pc_d    = rom_addr;
            pend_valid_d = 1'b1;
            if (halt_hit) begin
                state_d      = ST_HALT;
                pend_valid_d = 1'b0;
            end
        end else if ((state_q == ST_HALT) && !stall) begin
            // inst/pc keep showing the HALT word; only its valid flag drops.
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            pc_q         <= '0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            pc_q         <= pc_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign halted     = (state_q == ST_HALT);

endmodule
